// File: rtl/mindy_phase_sched.sv
// Round-robin phase scheduler: coalesces per-phase events and issues one frame command at a time.
// Optional watchdog on the completion wait is compiled in with MINDY_SCHED_WATCHDOG_EN.
module mindy_phase_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CTR_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [31:0]      frame_ctr0,
  input  logic [31:0]      frame_ctr1,
  input  logic [7:0]       AXIS_IN_TDATA,
  input  logic             AXIS_IN_TVALID,
  output logic             AXIS_IN_TREADY,
  output logic             CMD_PHASE,
  output logic [31:0]      CMD_FRAME,
  output logic             CMD_VALID,
  input  logic             CMD_READY,
  input  logic             CMD_DONE,
  output logic             busy,
  output logic [1:0]       pending,
  output logic [CTR_W-1:0] overrun_count,
  output logic [CTR_W-1:0] badid_count,
  output logic [CTR_W-1:0] timeout_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       ev_acc;
  logic       ev_ok;
  logic       ev_bad;
  logic       ev_id;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;
  logic       grant;
  logic       gnt_phase;

  always_comb begin
    ev_acc    = AXIS_IN_TVALID & AXIS_IN_TREADY;
    ev_ok     = ev_acc & ~(|AXIS_IN_TDATA[7:1]);
    ev_bad    = ev_acc & (|AXIS_IN_TDATA[7:1]);
    ev_id     = AXIS_IN_TDATA[0];
    grant     = (state == S_IDLE) & enable & (|pending);
    gnt_phase = (&pending) ? ~last_grant : pending[1];
    set_mask  = '0;
    clr_mask  = '0;
    if (ev_ok) set_mask[ev_id] = 1'b1;
    if (grant) clr_mask[gnt_phase] = 1'b1;
  end

  assign busy = (state != S_IDLE);

`ifdef MINDY_SCHED_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        wd_expire;

  assign wd_expire = (wd_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt        <= '0;
      timeout_count <= '0;
    end else begin
      if (state == S_ISSUE && CMD_READY) wd_cnt <= '0;
      else if (state == S_WAIT)           wd_cnt <= wd_cnt + 32'd1;
      // A completion on the expiry edge takes precedence over the timeout.
      if (state == S_WAIT && !CMD_DONE && wd_expire && timeout_count != '1)
        timeout_count <= timeout_count + CTR_W'(1);
    end
  end
`else
  assign timeout_count = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      AXIS_IN_TREADY <= 1'b0;
      pending        <= '0;
      overrun_count  <= '0;
      badid_count    <= '0;
    end else begin
      AXIS_IN_TREADY <= 1'b1;
      // Set after clear: an event landing on its own phase's grant edge stays pending.
      pending <= (pending & ~clr_mask) | set_mask;
      if (ev_ok && pending[ev_id] && overrun_count != '1)
        overrun_count <= overrun_count + CTR_W'(1);
      if (ev_bad && badid_count != '1)
        badid_count <= badid_count + CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      CMD_PHASE  <= 1'b0;
      CMD_FRAME  <= '0;
      CMD_VALID  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            CMD_PHASE  <= gnt_phase;
            CMD_FRAME  <= gnt_phase ? frame_ctr1 : frame_ctr0;
            CMD_VALID  <= 1'b1;
            last_grant <= gnt_phase;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (CMD_READY) begin
            CMD_VALID <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (CMD_DONE) state <= S_IDLE;
`ifdef MINDY_SCHED_WATCHDOG_EN
          else if (wd_expire) state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mindy_phase_sched.sv
// Directed bench for mindy_phase_sched; watchdog cases run only when MINDY_SCHED_WATCHDOG_EN is defined.
module tb_mindy_phase_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] frame_ctr0;
  logic [31:0] frame_ctr1;
  logic [7:0]  AXIS_IN_TDATA;
  logic        AXIS_IN_TVALID;
  logic        AXIS_IN_TREADY;
  logic        CMD_PHASE;
  logic [31:0] CMD_FRAME;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_DONE;
  logic        busy;
  logic [1:0]  pending;
  logic [7:0]  overrun_count;
  logic [7:0]  badid_count;
  logic [7:0]  timeout_count;

  int total = 0;
  int bad   = 0;

  mindy_phase_sched #(.TIMEOUT_CYCLES(16), .CTR_W(8)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .frame_ctr0     (frame_ctr0),
    .frame_ctr1     (frame_ctr1),
    .AXIS_IN_TDATA  (AXIS_IN_TDATA),
    .AXIS_IN_TVALID (AXIS_IN_TVALID),
    .AXIS_IN_TREADY (AXIS_IN_TREADY),
    .CMD_PHASE      (CMD_PHASE),
    .CMD_FRAME      (CMD_FRAME),
    .CMD_VALID      (CMD_VALID),
    .CMD_READY      (CMD_READY),
    .CMD_DONE       (CMD_DONE),
    .busy           (busy),
    .pending        (pending),
    .overrun_count  (overrun_count),
    .badid_count    (badid_count),
    .timeout_count  (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input logic [7:0] id);
    AXIS_IN_TDATA  = id;
    AXIS_IN_TVALID = 1'b1;
    tick();
    AXIS_IN_TVALID = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    AXIS_IN_TVALID = 1'b0;
    AXIS_IN_TDATA = '0;
    CMD_READY = 1'b0;
    CMD_DONE = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Handshake edge, then a DONE pulse; leaves the FSM back in IDLE.
  task automatic complete(input string tag);
    CMD_READY = 1'b1;
    tick();
    chk({tag, "_hs_valid"}, {31'd0, CMD_VALID}, 32'd0);
    chk({tag, "_hs_busy"}, {31'd0, busy}, 32'd1);
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    frame_ctr0 = '0;
    frame_ctr1 = '0;
    AXIS_IN_TDATA = '0;
    AXIS_IN_TVALID = 1'b0;
    CMD_READY = 1'b0;
    CMD_DONE = 1'b0;
    tick();
    tick();
    chk("rst_tready", {31'd0, AXIS_IN_TREADY}, 32'd0);
    chk("rst_valid", {31'd0, CMD_VALID}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pending", {30'd0, pending}, 32'd0);
    chk("rst_frame", CMD_FRAME, 32'd0);
    chk("rst_ovr", {24'd0, overrun_count}, 32'd0);
    chk("rst_bad", {24'd0, badid_count}, 32'd0);
    chk("rst_tmo", {24'd0, timeout_count}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("tready_up", {31'd0, AXIS_IN_TREADY}, 32'd1);

    // Single event, one-cycle grant latency
    enable = 1'b1;
    CMD_READY = 1'b1;
    frame_ctr0 = 32'h25;
    send_ev(8'd0);
    chk("t1_pend", {30'd0, pending}, 32'd1);
    chk("t1_valid_early", {31'd0, CMD_VALID}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, CMD_VALID}, 32'd1);
    chk("t1_phase", {31'd0, CMD_PHASE}, 32'd0);
    chk("t1_frame", CMD_FRAME, 32'h25);
    chk("t1_pend_clr", {30'd0, pending}, 32'd0);
    complete("t1");

    // Dual pending: alternation starting from phase 0
    do_reset();
    frame_ctr0 = 32'h100;
    frame_ctr1 = 32'h200;
    CMD_READY = 1'b1;
    send_ev(8'd0);
    send_ev(8'd1);
    chk("t2_pend", {30'd0, pending}, 32'd3);
    tick();
    chk("t2_hold", {31'd0, CMD_VALID}, 32'd0);
    enable = 1'b1;
    tick();
    chk("t2_a_valid", {31'd0, CMD_VALID}, 32'd1);
    chk("t2_a_phase", {31'd0, CMD_PHASE}, 32'd0);
    chk("t2_a_frame", CMD_FRAME, 32'h100);
    chk("t2_a_pend", {30'd0, pending}, 32'd2);
    complete("t2a");
    chk("t2_gap_valid", {31'd0, CMD_VALID}, 32'd0);
    tick();
    chk("t2_b_valid", {31'd0, CMD_VALID}, 32'd1);
    chk("t2_b_phase", {31'd0, CMD_PHASE}, 32'd1);
    chk("t2_b_frame", CMD_FRAME, 32'h200);
    complete("t2b");
    enable = 1'b0;
    send_ev(8'd1);
    send_ev(8'd0);
    enable = 1'b1;
    tick();
    chk("t2_c_phase", {31'd0, CMD_PHASE}, 32'd0);
    complete("t2c");
    tick();
    chk("t2_d_phase", {31'd0, CMD_PHASE}, 32'd1);
    chk("t2_d_valid", {31'd0, CMD_VALID}, 32'd1);
    complete("t2d");

    // Overrun coalescing and bad ids
    do_reset();
    enable = 1'b1;
    frame_ctr1 = 32'h77;
    send_ev(8'd1);
    tick();
    chk("t3_valid", {31'd0, CMD_VALID}, 32'd1);
    chk("t3_phase", {31'd0, CMD_PHASE}, 32'd1);
    send_ev(8'd1);
    send_ev(8'd1);
    send_ev(8'd1);
    send_ev(8'd7);
    chk("t3_ovr", {24'd0, overrun_count}, 32'd2);
    chk("t3_bad", {24'd0, badid_count}, 32'd1);
    chk("t3_pend", {30'd0, pending}, 32'd2);
    complete("t3a");
    tick();
    chk("t3_b_valid", {31'd0, CMD_VALID}, 32'd1);
    chk("t3_b_phase", {31'd0, CMD_PHASE}, 32'd1);
    chk("t3_b_pend", {30'd0, pending}, 32'd0);
    complete("t3b");
    tick();
    tick();
    tick();
    chk("t3_quiet_valid", {31'd0, CMD_VALID}, 32'd0);
    chk("t3_quiet_busy", {31'd0, busy}, 32'd0);
    chk("t3_quiet_pend", {30'd0, pending}, 32'd0);

    // Stall: command fields frozen while CMD_READY is low
    CMD_READY = 1'b0;
    frame_ctr0 = 32'h33;
    send_ev(8'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      frame_ctr0 = 32'h40 + 32'(i);
      tick();
      chk("t4_valid", {31'd0, CMD_VALID}, 32'd1);
      chk("t4_phase", {31'd0, CMD_PHASE}, 32'd0);
      chk("t4_frame", CMD_FRAME, 32'h33);
    end
    complete("t4");

    // Bad-id counter saturates
    for (int i = 0; i < 260; i++) send_ev(8'd9);
    chk("t5_bad_sat", {24'd0, badid_count}, 32'hff);
    chk("t5_busy", {31'd0, busy}, 32'd0);

    // Reset while in ISSUE
    CMD_READY = 1'b0;
    send_ev(8'd0);
    tick();
    send_ev(8'd1);
    chk("t6_pre_valid", {31'd0, CMD_VALID}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, CMD_VALID}, 32'd0);
    chk("t6_pend", {30'd0, pending}, 32'd0);
    chk("t6_bad", {24'd0, badid_count}, 32'd0);
    chk("t6_ovr", {24'd0, overrun_count}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    enable = 1'b0;
    CMD_READY = 1'b1;
    send_ev(8'd1);
    send_ev(8'd0);
    enable = 1'b1;
    tick();
    chk("t6_first_phase", {31'd0, CMD_PHASE}, 32'd0);
    complete("t6");

`ifdef MINDY_SCHED_WATCHDOG_EN
    // Watchdog expiry after 16 WAIT cycles
    send_ev(8'd0);
    tick();
    CMD_READY = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("wd_wait_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    chk("wd_exp_busy", {31'd0, busy}, 32'd0);
    chk("wd_exp_cnt", {24'd0, timeout_count}, 32'd1);
    // DONE on the expiry edge: no timeout counted
    send_ev(8'd1);
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("wd_race_busy_pre", {31'd0, busy}, 32'd1);
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    chk("wd_race_busy", {31'd0, busy}, 32'd0);
    chk("wd_race_cnt", {24'd0, timeout_count}, 32'd1);
`else
    chk("tmo_tied", {24'd0, timeout_count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mindy_phase_sched.md
Name: mindy_phase_sched

Overview:
Consumes the 8-bit phase-event stream that the mindy control block emits whenever a phase frame counter is updated. Tracks one pending request per phase (0 and 1) and arbitrates between the phases round-robin. Issues one frame command at a time to the downstream frame datapath over a valid/ready handshake, then waits for that datapath's completion pulse, guarded by an optional watchdog. Sits between the mindy control block and the frame mover.

Parameters:
TIMEOUT_CYCLES, 100000, watchdog limit in clk cycles for the WAIT state (used only when the watchdog is compiled in)
CTR_W, 8, width of the saturating overrun/timeout/error counters

Ports:
clk  input  1  the one clock; all logic rising-edge
resetn  input  1  reset, asynchronous, active-low
enable  input  1  1 = grants allowed; 0 = pending requests accumulate but none are granted
frame_ctr0  input  32  current frame number, phase 0
frame_ctr1  input  32  current frame number, phase 1
AXIS_IN_TDATA  input  8  phase-event id
AXIS_IN_TVALID  input  1  event valid
AXIS_IN_TREADY  output  1  event ready
CMD_PHASE  output  1  phase of issued command
CMD_FRAME  output  32  frame number of issued command
CMD_VALID  output  1  command valid
CMD_READY  input  1  datapath accepts command
CMD_DONE  input  1  single-cycle completion pulse from datapath
busy  output  1  FSM not in IDLE
pending  output  2  per-phase pending flags
overrun_count  output  CTR_W  events coalesced into an already-pending phase
badid_count  output  CTR_W  events dropped for illegal id
timeout_count  output  CTR_W  watchdog expiries

Behaviour:
- Reset (async assert, sync release): all outputs 0 and all counters 0; FSM enters IDLE; last_grant resets to 1, so phase 0 wins the first tie.
- AXIS_IN_TREADY = 1 whenever resetn = 1; it is a register, cleared by reset.
- An event is accepted on any edge where TVALID and TREADY are both 1:
  - TDATA = 0 or 1: sets pending[TDATA].
  - If that phase is already pending: overrun_count increments (saturating at all-ones); the request is coalesced.
  - TDATA > 1: dropped; badid_count increments (saturating).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if enable = 1 and pending != 0, grant a phase:
  - Both pending: grant the phase != last_grant.
  - Otherwise grant the single pending phase.
  - On the grant edge: latch CMD_PHASE and CMD_FRAME (frame_ctr0 or frame_ctr1 as sampled that edge), clear pending[p], set last_grant = p, go to ISSUE with CMD_VALID = 1.
- ISSUE: hold CMD_VALID, CMD_PHASE and CMD_FRAME stable until CMD_READY = 1. On the handshake edge: CMD_VALID <= 0, clear the watchdog counter, go to WAIT.
- WAIT: on CMD_DONE = 1, go to IDLE.
- CMD_DONE is ignored in IDLE and ISSUE.
- Latency: event accepted at edge k with FSM idle and enable = 1 -> CMD_VALID = 1 after edge k+1. Back-to-back: IDLE spends at least one cycle between the DONE edge and the next grant.
- Same-edge event and grant for the same phase: set wins, so pending[p] remains 1 and a second command follows.
- enable deasserted while in ISSUE or WAIT: the current command completes normally; no new grant is made.
- Reset mid-operation: everything returns to reset values immediately; CMD_VALID drops asynchronously; pending requests are discarded.
- Counters saturate and never wrap.

Optional Feature:
MINDY_SCHED_WATCHDOG_EN
- Defined: a 32-bit counter increments each cycle in WAIT. When it reaches TIMEOUT_CYCLES-1 without CMD_DONE: timeout_count increments (saturating) and the FSM returns to IDLE.
- CMD_DONE on the expiry edge wins: no timeout is counted.
- Not defined: WAIT holds indefinitely until CMD_DONE; timeout_count is tied to 0; no counter logic is synthesized.

Test Plan:
- Single event TDATA=0, frame_ctr0=0x25, CMD_READY=1 -> CMD_VALID=1 one cycle after the accept edge, CMD_PHASE=0, CMD_FRAME=0x25; DONE pulse -> busy=0.
- Events 0 and 1 both pending with enable=0, then enable=1 -> grants phase 0 then phase 1. A subsequent dual pending state -> grants phase 0 first again (alternation continues from last_grant=1).
- Three TDATA=1 events while the phase-1 command is outstanding -> overrun_count=2 and exactly one further phase-1 command. TDATA=7 -> badid_count=1, no command issued.
- CMD_READY held 0 for 10 cycles -> CMD_VALID, CMD_PHASE and CMD_FRAME stable throughout; frame_ctr0 changes in that window do not alter CMD_FRAME.
- WATCHDOG_EN, TIMEOUT_CYCLES=16, no DONE -> timeout_count=1 after 16 WAIT cycles, FSM returns to IDLE. DONE on the expiry edge -> timeout_count unchanged.
- resetn low while in ISSUE -> CMD_VALID=0 immediately; pending=0 and all counters 0; the first grant after release is phase 0.
